uart_packet_controller: RTL

Sequences the UART byte link into framed command packets for the series-preprocessing pipeline. It parses bytes delivered by the UART receiver into header/cmd/len/payload/checksum frames and buffers the payload until the checksum is verified. Verified payloads are streamed downstream with valid/ready. For every frame, the block returns a one-byte ACK or NAK through the UART transmitter. It sits between the UART interface and the downstream processing logic and is the only driver of the transmitter's send/data inputs.

---
 rtl/uart_packet_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_packet_controller: parses A5/CMD/LEN/payload/CHK frames from the     |
// | UART byte link, streams verified payloads and answers each with ACK/NAK.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_packet_controller #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_ready,
  output logic [7:0] cmd_out,
  output logic [7:0] len_out,
  output logic       cmd_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [2:0] C_S_IDLE    = 3'd0;
  localparam logic [2:0] C_S_CMD     = 3'd1;
  localparam logic [2:0] C_S_LEN     = 3'd2;
  localparam logic [2:0] C_S_PAYLOAD = 3'd3;
  localparam logic [2:0] C_S_CHK     = 3'd4;
  localparam logic [2:0] C_S_DRAIN   = 3'd5;
  localparam logic [2:0] C_S_RESP    = 3'd6;

  localparam logic [7:0] C_SOF     = 8'hA5;
  localparam logic [7:0] C_ACK     = 8'h06;
  localparam logic [7:0] C_NAK     = 8'h15;
  localparam logic [7:0] C_MAX_LEN = 8'(MAX_LEN);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    xor_q, xor_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          nak_q, nak_d;
  logic [7:0]    cmd_out_q, cmd_out_d;
  logic [7:0]    len_out_q, len_out_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          busy_q, busy_d;

  logic [7:0]    pay_mem [MAX_LEN];
  logic          w_buf_we;
  logic          w_timed;
  logic          w_tmo_hit;
  logic          w_drain;
  logic          w_last;
  logic          w_resp;

  assign w_drain = (state_q == C_S_DRAIN);
  assign w_resp  = (state_q == C_S_RESP);
  assign w_last  = w_drain && (rd_ptr_q == len_q - 8'd1);
  assign w_timed = (state_q == C_S_CMD) || (state_q == C_S_LEN) ||
                   (state_q == C_S_PAYLOAD) || (state_q == C_S_CHK);
  // rx_valid wins over an expiring timer on the same edge
  assign w_tmo_hit = w_timed && !rx_valid && (tmo_q == C_TMO_LAST);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    xor_d       = xor_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    nak_d       = nak_q;
    cmd_out_d   = cmd_out_q;
    len_out_d   = len_out_q;
    cmd_valid_d = 1'b0;
    err_count_d = err_count_q;
    w_buf_we    = 1'b0;
    tmo_d       = (w_timed && !rx_valid) ? tmo_q + TW'(1) : '0;

    case (state_q)
      C_S_IDLE: begin
        if (rx_valid && rx_data == C_SOF) state_d = C_S_CMD;
      end
      C_S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          xor_d   = rx_data;
          state_d = C_S_LEN;
        end
      end
      C_S_LEN: begin
        if (rx_valid) begin
          len_d    = rx_data;
          xor_d    = xor_q ^ rx_data;
          wr_ptr_d = 8'd0;
          if (rx_data > C_MAX_LEN) begin
            nak_d   = 1'b1;
            state_d = C_S_RESP;
          end else if (rx_data == 8'd0) begin
            state_d = C_S_CHK;
          end else begin
            state_d = C_S_PAYLOAD;
          end
        end
      end
      C_S_PAYLOAD: begin
        if (rx_valid) begin
          w_buf_we = 1'b1;
          xor_d    = xor_q ^ rx_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q + 8'd1 == len_q) state_d = C_S_CHK;
        end
      end
      C_S_CHK: begin
        if (rx_valid) begin
          if (rx_data != xor_q) begin
            nak_d   = 1'b1;
            state_d = C_S_RESP;
          end else begin
            cmd_out_d   = cmd_q;
            len_out_d   = len_q;
            cmd_valid_d = 1'b1;
            rd_ptr_d    = 8'd0;
            nak_d       = 1'b0;
            state_d     = (len_q == 8'd0) ? C_S_RESP : C_S_DRAIN;
          end
        end
      end
      C_S_DRAIN: begin
        if (pkt_ready) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
          if (w_last) begin
            nak_d   = 1'b0;
            state_d = C_S_RESP;
          end
        end
      end
      C_S_RESP: begin
        if (tx_ready) begin
          state_d = C_S_IDLE;
          if (nak_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = C_S_IDLE;
    endcase

    if (w_tmo_hit) begin
      nak_d   = 1'b1;
      state_d = C_S_RESP;
    end

    busy_d = (state_d != C_S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= C_S_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      xor_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      tmo_q       <= '0;
      nak_q       <= 1'b0;
      cmd_out_q   <= 8'd0;
      len_out_q   <= 8'd0;
      cmd_valid_q <= 1'b0;
      err_count_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      xor_q       <= xor_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      nak_q       <= nak_d;
      cmd_out_q   <= cmd_out_d;
      len_out_q   <= len_out_d;
      cmd_valid_q <= cmd_valid_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  // Payload store is a plain memory; stale entries beyond LEN are never read
  always_ff @(posedge clk) begin
    if (w_buf_we) pay_mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  assign pkt_valid = w_drain;
  assign pkt_last  = w_last;
  assign pkt_data  = w_drain ? pay_mem[rd_ptr_q[AW-1:0]] : 8'd0;
  assign tx_send   = w_resp && tx_ready;
  assign tx_data   = w_resp ? (nak_q ? C_NAK : C_ACK) : 8'd0;
  assign cmd_out   = cmd_out_q;
  assign len_out   = len_out_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire
